awgn_sweep_ctrl: RTL
====================

AWGN_SWEEP_CTRL -- requirements
Module: awgn_sweep_ctrl

Interface
REQ-001 SHALL have parameter BI, default 24, sample width in bits for each of real and imag.
REQ-002 SHALL have parameter FRAME_LEN, default 320000, samples sent per SNR point (range 1..2^20-1).
REQ-003 SHALL have parameter SNR_MIN, default 0, first SNR point in dB (range 0..9).
REQ-004 SHALL have parameter SNR_MAX, default 9, last SNR point in dB (SNR_MIN <= SNR_MAX <= 9).
REQ-005 SHALL have parameter CH_LAT, default 1, channel latency in cycles from ch_read to valid ch_Y (range 1..8).
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; reset  in  1  async active-low reset.
REQ-007 SHALL have ports start  in  1  one-cycle sweep request; abort  in  1  cancel sweep.
REQ-008 SHALL have ports src_valid  in  1;  src_ready  out  1;  src_real, src_imag  in  BI  signed source samples.
REQ-009 SHALL have ports ch_read  out  1;  ch_X_in_real, ch_X_in_imag  out  BI  channel inputs;  ch_Y_real, ch_Y_imag  in  BI  channel outputs;  snr_sel  out  4  channel SNR select.
REQ-010 SHALL have ports out_valid  out  1;  out_real, out_imag  out  BI;  out_snr  out  4  SNR tag of the output sample.
REQ-011 SHALL have ports busy  out  1;  sample_cnt  out  20  transfers in current point;  point_done  out  1  pulse;  sweep_done  out  1  pulse.

Function
REQ-012 SHALL implement FSM IDLE, LOAD, STREAM, DRAIN, NEXT; busy = 1 in every state except IDLE.
REQ-013 In IDLE, start=1 SHALL go to LOAD with snr_sel = SNR_MIN; start SHALL be ignored in any other state.
REQ-014 LOAD SHALL last exactly 1 cycle, clear sample_cnt, and go to STREAM; snr_sel SHALL stay stable from LOAD to NEXT.
REQ-015 src_ready SHALL be 1 only in STREAM; a transfer occurs when src_valid and src_ready are both 1 on a rising edge.
REQ-016 On each transfer, ch_X_in_real and ch_X_in_imag SHALL register src_real and src_imag, and ch_read SHALL be 1 for exactly the next cycle; otherwise ch_read = 0 and ch_X holds its value.
REQ-017 sample_cnt SHALL increment on each transfer; the transfer that makes sample_cnt = FRAME_LEN SHALL move the FSM to DRAIN, so src_ready = 0 from the next cycle.
REQ-018 A CH_LAT-deep valid/tag shift register SHALL follow each ch_read; exactly CH_LAT cycles after ch_read, out_valid SHALL be 1 for one cycle with out_real/out_imag = ch_Y sampled that cycle and out_snr = snr_sel of the transfer.
REQ-019 out_real, out_imag and out_snr SHALL hold their value while out_valid = 0.
REQ-020 DRAIN SHALL stay until ch_read and the shift register are all 0, then go to NEXT.
REQ-021 NEXT SHALL pulse point_done for 1 cycle; if snr_sel = SNR_MAX it SHALL also pulse sweep_done and go to IDLE, else it SHALL increment snr_sel and go to LOAD.
REQ-022 abort SHALL have priority over all other inputs, including start in the same cycle; it SHALL force IDLE and flush ch_read and the shift register on the next edge, with no point_done or sweep_done pulse.
REQ-023 Counter width arithmetic SHALL NOT wrap: sample_cnt saturates at FRAME_LEN.

Reset
REQ-024 reset = 0 SHALL asynchronously force IDLE and clear all outputs and registers to 0 (snr_sel = SNR_MIN, sample_cnt = 0); a reset during STREAM SHALL discard all in-flight samples.
REQ-025 Release of reset SHALL be synchronised to clk; the first start is accepted on the second edge after reset rises.

Verification (FRAME_LEN=4, CH_LAT=1, SNR_MIN=7, SNR_MAX=8 unless stated)
REQ-026 start pulse, src_valid held 1 with samples 1..8 -> ch_read pulses 4 per point; out_valid 8 times with out_snr 7,7,7,7,8,8,8,8; point_done 2 times; sweep_done once at the end; busy = 0 afterwards.
REQ-027 ch_Y_real = ch_X_in_real + 5 loopback, src_real = 100 -> out_real = 105 exactly 1 cycle after ch_read; with CH_LAT=3 -> 3 cycles after.
REQ-028 src_valid toggling 1,0,1,0 during STREAM -> sample_cnt advances only on valid cycles; no extra ch_read; src_ready = 0 after the 4th transfer.
REQ-029 abort asserted after the 2nd transfer of SNR 7 -> IDLE next cycle, no further out_valid, point_done = 0, sweep_done = 0; start and abort in the same cycle -> stays IDLE.
REQ-030 reset = 0 mid-STREAM, asynchronous to clk -> all outputs 0 immediately; start after release -> sweep restarts at snr_sel = 7 with sample_cnt = 0.
REQ-031 SNR_MIN = SNR_MAX = 9 and FRAME_LEN = 1 -> one ch_read, one out_valid, point_done and sweep_done in the same cycle.

Source files
------------

// File: rtl/awgn_sweep_ctrl.sv
// awgn_sweep_ctrl: steps an AWGN channel through SNR points SNR_MIN..SNR_MAX, streaming FRAME_LEN source samples per point.
// Latency: 1 cycle from source transfer to ch_read, then CH_LAT cycles from ch_read to out_valid.
// Backpressure: src_ready is high only while streaming; no output backpressure (out_valid is a one-cycle strobe).
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   start, abort             one-cycle sweep request; abort cancels and wins over everything
//   src_valid/src_ready      source handshake, src_real/src_imag signed samples
//   ch_read, ch_X_in_*       registered sample into the channel, ch_read strobes for one cycle per transfer
//   ch_Y_*                   channel output, valid CH_LAT cycles after ch_read
//   snr_sel                  SNR point fed to the channel, stable for a whole point
//   out_valid, out_*         channel result with the SNR tag of its transfer; values hold while out_valid = 0
//   busy, sample_cnt         status; point_done and sweep_done are one-cycle pulses
module awgn_sweep_ctrl #(
   parameter int BI        = 24,
   parameter int FRAME_LEN = 320000,
   parameter int SNR_MIN   = 0,
   parameter int SNR_MAX   = 9,
   parameter int CH_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic signed [BI-1:0] src_real,
   input  logic signed [BI-1:0] src_imag,
   output logic                 ch_read,
   output logic signed [BI-1:0] ch_X_in_real,
   output logic signed [BI-1:0] ch_X_in_imag,
   input  logic signed [BI-1:0] ch_Y_real,
   input  logic signed [BI-1:0] ch_Y_imag,
   output logic [3:0]           snr_sel,
   output logic                 out_valid,
   output logic signed [BI-1:0] out_real,
   output logic signed [BI-1:0] out_imag,
   output logic [3:0]           out_snr,
   output logic                 busy,
   output logic [19:0]          sample_cnt,
   output logic                 point_done,
   output logic                 sweep_done
);

   localparam logic [3:0]  SNR_LO    = 4'(SNR_MIN);
   localparam logic [3:0]  SNR_HI    = 4'(SNR_MAX);
   localparam logic [19:0] FRAME_END = 20'(FRAME_LEN);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_NEXT} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               snr_q, snr_d;
   logic [19:0]              cnt_q, cnt_d;
   logic                     ch_read_q, ch_read_d;
   logic signed [BI-1:0]     x_re_q, x_re_d;
   logic signed [BI-1:0]     x_im_q, x_im_d;
   logic [CH_LAT-1:0]        vld_sr_q, vld_sr_d;
   logic [CH_LAT-1:0][3:0]   tag_sr_q, tag_sr_d;
   logic signed [BI-1:0]     hold_re_q, hold_re_d;
   logic signed [BI-1:0]     hold_im_q, hold_im_d;
   logic [3:0]               hold_snr_q, hold_snr_d;
   // Reset release qualifier: the edge that first sees rst_n high only arms
   // this flop, so start is honoured from the second edge onwards.
   logic                     start_en_q, start_en_d;

   // Output side: the channel result is passed through in the cycle the
   // tag pipeline says it is valid, otherwise the last result is held.
   assign out_valid = vld_sr_q[CH_LAT-1];
   assign out_real  = out_valid ? ch_Y_real : hold_re_q;
   assign out_imag  = out_valid ? ch_Y_imag : hold_im_q;
   assign out_snr   = out_valid ? tag_sr_q[CH_LAT-1] : hold_snr_q;

   assign src_ready    = (state_q == S_STREAM);
   assign busy         = (state_q != S_IDLE);
   assign point_done   = (state_q == S_NEXT);
   assign sweep_done   = (state_q == S_NEXT) && (snr_q == SNR_HI);
   assign ch_read      = ch_read_q;
   assign ch_X_in_real = x_re_q;
   assign ch_X_in_imag = x_im_q;
   assign snr_sel      = snr_q;
   assign sample_cnt   = cnt_q;

   always_comb begin
      state_d    = state_q;
      snr_d      = snr_q;
      cnt_d      = cnt_q;
      ch_read_d  = 1'b0;
      x_re_d     = x_re_q;
      x_im_d     = x_im_q;
      start_en_d = 1'b1;
      hold_re_d  = out_real;
      hold_im_d  = out_imag;
      hold_snr_d = out_snr;

      // Valid/tag pipeline: stage 0 follows ch_read, last stage is out_valid.
      vld_sr_d[0] = ch_read_q;
      tag_sr_d[0] = snr_q;
      for (int i = 1; i < CH_LAT; i++) begin
         vld_sr_d[i] = vld_sr_q[i-1];
         tag_sr_d[i] = tag_sr_q[i-1];
      end

      if (abort) begin
         // Cancel: drop everything in flight, no completion pulses.
         state_d   = S_IDLE;
         snr_d     = SNR_LO;
         cnt_d     = '0;
         ch_read_d = 1'b0;
         vld_sr_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && start_en_q) begin
                  state_d = S_LOAD;
                  snr_d   = SNR_LO;
               end
            end
            S_LOAD: begin
               cnt_d   = '0;
               state_d = S_STREAM;
            end
            S_STREAM: begin
               if (src_valid) begin
                  ch_read_d = 1'b1;
                  x_re_d    = src_real;
                  x_im_d    = src_imag;
                  if (cnt_q < FRAME_END) begin
                     cnt_d = cnt_q + 20'd1;
                  end
                  if (cnt_q >= FRAME_END - 20'd1) begin
                     state_d = S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // Wait for the last sample of the point to leave the channel.
               if (!ch_read_q && (vld_sr_q == '0)) begin
                  state_d = S_NEXT;
               end
            end
            S_NEXT: begin
               if (snr_q == SNR_HI) begin
                  state_d = S_IDLE;
                  snr_d   = SNR_LO;
               end else begin
                  snr_d   = snr_q + 4'd1;
                  state_d = S_LOAD;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         snr_q      <= SNR_LO;
         cnt_q      <= '0;
         ch_read_q  <= 1'b0;
         x_re_q     <= '0;
         x_im_q     <= '0;
         vld_sr_q   <= '0;
         tag_sr_q   <= '0;
         hold_re_q  <= '0;
         hold_im_q  <= '0;
         hold_snr_q <= '0;
         start_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         snr_q      <= snr_d;
         cnt_q      <= cnt_d;
         ch_read_q  <= ch_read_d;
         x_re_q     <= x_re_d;
         x_im_q     <= x_im_d;
         vld_sr_q   <= vld_sr_d;
         tag_sr_q   <= tag_sr_d;
         hold_re_q  <= hold_re_d;
         hold_im_q  <= hold_im_d;
         hold_snr_q <= hold_snr_d;
         start_en_q <= start_en_d;
      end
   end

endmodule
